scenario_player: RTL and testbench

Parametrised hardware stimulus sequencer. It holds a loaded list of timed entries and plays them to NUM_CH independent valid/ready output channels. Each entry carries a target channel, a pre-issue delay and a data word. It supports one-shot and looping playback, abort, and error reporting. It sits between the bench configuration/scenario loader and the DUT-side interfaces, so a scenario runs at full clock rate without per-cycle bench involvement.

---
 rtl/scenario_player_pkg.sv | 35 +++
 rtl/scenario_store.sv | 38 +++
 rtl/scenario_player.sv | 221 ++++++++++++++++++++++
 tb/tb_scenario_player.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/scenario_player_pkg.sv
// Shared types and derived widths for the scenario player.
package scenario_player_pkg;

    localparam int unsigned SP_NUM_CH = 4;
    localparam int unsigned SP_DATA_W = 32;
    localparam int unsigned SP_DEPTH  = 16;
    localparam int unsigned SP_DLY_W  = 8;

    localparam int unsigned CH_W  = (SP_NUM_CH > 1) ? $clog2(SP_NUM_CH) : 1;
    localparam int unsigned PTR_W = $clog2(SP_DEPTH);
    localparam int unsigned CNT_W = $clog2(SP_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [CH_W-1:0]      ch;
        logic [SP_DLY_W-1:0]  dly;
        logic [SP_DATA_W-1:0] data;
    } entry_t;

    // Fold an out-of-range channel index back into 0..NUM_CH-1 (only matters
    // when NUM_CH is not a power of two).
    function automatic logic [CH_W-1:0] ch_fold(input logic [CH_W-1:0] ch);
        if (32'(ch) >= SP_NUM_CH) begin
            return ch - CH_W'(SP_NUM_CH);
        end
        return ch;
    endfunction

endpackage

// File: rtl/scenario_store.sv
// Entry store: register array with one write port at index count and an
// asynchronous read port at rd_ptr. Array contents are never reset.
module scenario_store
    import scenario_player_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             wr_en,
    input  entry_t           wr_entry,
    input  logic [PTR_W-1:0] rd_ptr,
    output entry_t           rd_entry,
    output logic [CNT_W-1:0] count
);

    entry_t mem [SP_DEPTH];

    // Append the incoming entry at the current fill level.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count[PTR_W-1:0]] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_ptr];

    // Fill level; clear wins over a simultaneous write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/scenario_player.sv
// Timed stimulus sequencer: plays stored entries to NUM_CH valid/ready channels.
module scenario_player
    import scenario_player_pkg::*;
#(
    parameter int unsigned NUM_CH = SP_NUM_CH,
    parameter int unsigned DATA_W = SP_DATA_W,
    parameter int unsigned DEPTH  = SP_DEPTH,
    parameter int unsigned DLY_W  = SP_DLY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [CH_W-1:0]          load_ch,
    input  logic [DLY_W-1:0]         load_dly,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     clear,
    input  logic                     start,
    input  logic                     loop_en,
    input  logic                     stop,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [CNT_W-1:0]         count,
    output logic [15:0]              loop_cnt
);

    // Entry layout lives in the package, so the parameters must agree with it.
    if (NUM_CH != SP_NUM_CH || DATA_W != SP_DATA_W ||
        DEPTH != SP_DEPTH || DLY_W != SP_DLY_W) begin : g_param_check
        $error("scenario_player parameters differ from scenario_player_pkg");
    end

    state_t                   state, state_nxt;
    logic [PTR_W-1:0]         rd_ptr, rd_ptr_nxt;
    logic [DLY_W-1:0]         dly_cnt, dly_cnt_nxt;
    logic                     dly_ld, dly_ld_nxt;
    logic                     loop_q, loop_q_nxt;
    logic                     stop_pend, stop_pend_nxt;
    logic [15:0]              loop_cnt_nxt;
    logic [NUM_CH-1:0]        valid_nxt;
    logic [NUM_CH*DATA_W-1:0] data_nxt;
    logic                     load_ready_nxt;
    logic                     busy_nxt;
    logic                     done_nxt;
    logic                     err_nxt;

    entry_t                   rd_entry;
    entry_t                   wr_entry;
    logic                     ctl_c;
    logic                     clear_fire_c;
    logic                     load_fire_c;
    logic [CNT_W-1:0]         cnt_after_c;
    logic [CNT_W-1:0]         cnt_nxt_c;
    logic [CH_W-1:0]          cur_ch_c;
    logic                     hs_c;
    logic                     last_c;
    logic [DLY_W-1:0]         eff_dly_c;

    assign wr_entry = '{ch: load_ch, dly: load_dly, data: load_data};

    scenario_store u_store (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_fire_c),
        .wr_en    (load_fire_c),
        .wr_entry (wr_entry),
        .rd_ptr   (rd_ptr),
        .rd_entry (rd_entry),
        .count    (count)
    );

    // Control decode shared by the FSM and the store.
    always_comb begin
        ctl_c        = (state == ST_IDLE) || (state == ST_DONE);
        clear_fire_c = clear && ctl_c;
        load_fire_c  = load_valid && load_ready && !clear_fire_c;
        cnt_after_c  = count + (load_fire_c ? CNT_W'(1) : CNT_W'(0));
        cnt_nxt_c    = clear_fire_c ? '0 : cnt_after_c;
        cur_ch_c     = ch_fold(rd_entry.ch);
        hs_c         = (state == ST_DRIVE) && out_valid[cur_ch_c] && out_ready[cur_ch_c];
        last_c       = (CNT_W'(rd_ptr) == (count - CNT_W'(1)));
        eff_dly_c    = dly_ld ? rd_entry.dly : dly_cnt;
    end

    // State and playback registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_ptr    <= '0;
            dly_cnt   <= '0;
            dly_ld    <= 1'b0;
            loop_q    <= 1'b0;
            stop_pend <= 1'b0;
            loop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            rd_ptr    <= rd_ptr_nxt;
            dly_cnt   <= dly_cnt_nxt;
            dly_ld    <= dly_ld_nxt;
            loop_q    <= loop_q_nxt;
            stop_pend <= stop_pend_nxt;
            loop_cnt  <= loop_cnt_nxt;
        end
    end

    // Next-state logic; the entry delay is read one cycle after entering WAIT
    // so the single store read port always points at the entry being timed.
    always_comb begin
        state_nxt     = state;
        rd_ptr_nxt    = rd_ptr;
        dly_cnt_nxt   = dly_cnt;
        dly_ld_nxt    = dly_ld;
        loop_q_nxt    = loop_q;
        stop_pend_nxt = stop_pend;
        loop_cnt_nxt  = loop_cnt;
        err_nxt       = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (clear_fire_c) begin
                    loop_cnt_nxt = '0;
                    state_nxt    = ST_IDLE;
                end else if (start) begin
                    if (cnt_after_c == '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        rd_ptr_nxt    = '0;
                        dly_ld_nxt    = 1'b1;
                        loop_q_nxt    = loop_en;
                        loop_cnt_nxt  = '0;
                        stop_pend_nxt = 1'b0;
                        state_nxt     = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    stop_pend_nxt = 1'b0;
                    state_nxt     = ST_DONE;
                end else if (eff_dly_c == '0) begin
                    dly_ld_nxt = 1'b0;
                    state_nxt  = ST_DRIVE;
                end else begin
                    dly_cnt_nxt = eff_dly_c - DLY_W'(1);
                    dly_ld_nxt  = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (stop) begin
                    stop_pend_nxt = 1'b1;
                end
                if (hs_c) begin
                    if (stop || stop_pend) begin
                        stop_pend_nxt = 1'b0;
                        state_nxt     = ST_DONE;
                    end else if (last_c) begin
                        if (loop_q) begin
                            rd_ptr_nxt = '0;
                            dly_ld_nxt = 1'b1;
                            if (loop_cnt != 16'hFFFF) begin
                                loop_cnt_nxt = loop_cnt + 16'd1;
                            end
                            state_nxt = ST_WAIT;
                        end else begin
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        rd_ptr_nxt = rd_ptr + PTR_W'(1);
                        dly_ld_nxt = 1'b1;
                        state_nxt  = ST_WAIT;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values; valid rises one cycle into DRIVE and drops on the handshake.
    always_comb begin
        valid_nxt      = '0;
        data_nxt       = '0;
        busy_nxt       = (state == ST_WAIT) || (state == ST_DRIVE);
        done_nxt       = (state == ST_DONE);
        load_ready_nxt = ((state_nxt == ST_IDLE) || (state_nxt == ST_DONE)) &&
                         (cnt_nxt_c < CNT_W'(DEPTH));
        if ((state == ST_DRIVE) && !hs_c) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (CH_W'(c) == cur_ch_c) begin
                    valid_nxt[c]                 = 1'b1;
                    data_nxt[c*DATA_W +: DATA_W] = rd_entry.data;
                end
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= '0;
            out_data   <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            out_valid  <= valid_nxt;
            out_data   <= data_nxt;
            load_ready <= load_ready_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_scenario_player.sv
// Directed bench for scenario_player with hand-computed cycle expectations.
module tb_scenario_player;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [1:0]   load_ch;
    logic [7:0]   load_dly;
    logic [31:0]  load_data;
    logic         clear;
    logic         start;
    logic         loop_en;
    logic         stop;
    logic [3:0]   out_valid;
    logic [127:0] out_data;
    logic [3:0]   out_ready;
    logic         busy;
    logic         done;
    logic         err;
    logic [4:0]   count;
    logic [15:0]  loop_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    logic [3:0]   ev;
    logic [127:0] ed;

    scenario_player dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_ch    (load_ch),
        .load_dly   (load_dly),
        .load_data  (load_data),
        .clear      (clear),
        .start      (start),
        .loop_en    (loop_en),
        .stop       (stop),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count),
        .loop_cnt   (loop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] ch, input logic [7:0] dly, input logic [31:0] data);
        load_valid = 1'b1;
        load_ch    = ch;
        load_dly   = dly;
        load_data  = data;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_start(input logic lp);
        start   = 1'b1;
        loop_en = lp;
        tick();
        start   = 1'b0;
        loop_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_ch = '0; load_dly = '0; load_data = '0;
        clear = 1'b0; start = 1'b0; loop_en = 1'b0; stop = 1'b0; out_ready = 4'b1111;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst valid", out_valid, 0);
        chk("rst data", out_data, 0);
        chk("rst load_ready", load_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst count", count, 0);
        chk("rst loop_cnt", loop_cnt, 0);

        // One-shot playback, ready always high.
        load(2'd0, 8'd0, 32'h0000_000A);
        load(2'd2, 8'd3, 32'h0000_000B);
        load(2'd1, 8'd1, 32'h0000_000C);
        chk("t1 count", count, 3);
        do_start(1'b0);
        for (int k = 1; k <= 14; k++) begin
            tick();
            ev = '0; ed = '0;
            case (k)
                2:  begin ev = 4'b0001; ed[31:0]  = 32'hA; end
                8:  begin ev = 4'b0100; ed[95:64] = 32'hB; end
                12: begin ev = 4'b0010; ed[63:32] = 32'hC; end
                default: ;
            endcase
            chk($sformatf("t1 valid k%0d", k), out_valid, ev);
            chk($sformatf("t1 data k%0d", k), out_data, ed);
            if (k == 13) begin
                chk("t1 done k13", done, 0);
                chk("t1 busy k13", busy, 1);
            end
        end
        chk("t1 done", done, 1);
        chk("t1 busy", busy, 0);
        chk("t1 loop_cnt", loop_cnt, 0);

        // Replay with backpressure on channel 2.
        out_ready = 4'b1011;
        do_start(1'b0);
        for (int k = 1; k <= 18; k++) begin
            tick();
            ev = '0; ed = '0;
            if (k == 2) begin
                ev = 4'b0001; ed[31:0] = 32'hA;
            end else if (k >= 8 && k <= 11) begin
                ev = 4'b0100; ed[95:64] = 32'hB;
            end else if (k == 15) begin
                ev = 4'b0010; ed[63:32] = 32'hC;
            end
            chk($sformatf("t2 valid k%0d", k), out_valid, ev);
            chk($sformatf("t2 data k%0d", k), out_data, ed);
            if (k == 11) out_ready = 4'b1111;
            if (k == 17) chk("t2 done k17", done, 1);
        end

        // Looping playback, stop while a valid is held.
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t3 clear count", count, 0);
        load(2'd3, 8'd0, 32'h11);
        load(2'd0, 8'd1, 32'h22);
        do_start(1'b1);
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 7)  chk("t3 loop_cnt k7", loop_cnt, 1);
            if (k == 14) chk("t3 loop_cnt k14", loop_cnt, 2);
            if (k == 20) begin
                ed = '0; ed[31:0] = 32'h22;
                chk("t3 valid k20", out_valid, 4'b0001);
                chk("t3 data k20", out_data, ed);
            end
            if (k == 21) begin
                chk("t3 loop_cnt k21", loop_cnt, 3);
                out_ready = 4'b0000;
            end
            if (k >= 23 && k <= 25) begin
                ed = '0; ed[127:96] = 32'h11;
                chk($sformatf("t3 held valid k%0d", k), out_valid, 4'b1000);
                chk($sformatf("t3 held data k%0d", k), out_data, ed);
            end
            if (k == 23) stop = 1'b1;
            if (k == 24) stop = 1'b0;
            if (k == 25) out_ready = 4'b1111;
            if (k == 26) chk("t3 valid k26", out_valid, 0);
            if (k == 27) chk("t3 done k27", done, 1);
            if (k >= 28) chk($sformatf("t3 quiet k%0d", k), out_valid, 0);
        end
        chk("t3 loop_cnt end", loop_cnt, 3);
        chk("t3 busy end", busy, 0);

        // Fill the store, overflow attempt, then clear.
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t4 loop_cnt cleared", loop_cnt, 0);
        chk("t4 ready empty", load_ready, 1);
        for (int i = 0; i < 16; i++) load(2'(i), 8'd0, 32'(i));
        chk("t4 count full", count, 16);
        chk("t4 ready full", load_ready, 0);
        load(2'd1, 8'd0, 32'hDEAD);
        chk("t4 count overflow", count, 16);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("t4 count cleared", count, 0);
        chk("t4 ready cleared", load_ready, 1);

        // Empty start raises err for one cycle and stays idle.
        do_start(1'b0);
        chk("t5 err", err, 1);
        chk("t5 busy", busy, 0);
        tick();
        chk("t5 err drop", err, 0);
        chk("t5 idle busy", busy, 0);
        chk("t5 idle done", done, 0);
        chk("t5 idle ready", load_ready, 1);

        // Start during WAIT is ignored; valid held for the reset test.
        load(2'd1, 8'd5, 32'h33);
        load(2'd2, 8'd0, 32'h44);
        out_ready = 4'b0000;
        do_start(1'b0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
            if (k == 6) chk("t5 valid k6", out_valid, 0);
            if (k == 7 || k == 9) begin
                ed = '0; ed[63:32] = 32'h33;
                chk($sformatf("t5 valid k%0d", k), out_valid, 4'b0010);
                chk($sformatf("t5 data k%0d", k), out_data, ed);
            end
        end
        chk("t6 busy before rst", busy, 1);

        // Reset while driving channel 1.
        rst = 1'b1;
        #1;
        chk("t6 valid", out_valid, 0);
        chk("t6 data", out_data, 0);
        chk("t6 busy", busy, 0);
        chk("t6 count", count, 0);
        chk("t6 done", done, 0);
        chk("t6 ready", load_ready, 1);
        tick();
        rst = 1'b0;
        out_ready = 4'b1111;
        do_start(1'b0);
        chk("t6 err after rst", err, 1);
        chk("t6 busy after rst", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
